// File: rtl/dot_int_acc_pipe_if.sv
// Stream interface for the integer dot-product accumulator.
// Input side carries one vector pair per beat; output side carries the accumulated result.
interface dot_int_acc_pipe_if #(
   parameter int unsigned BitWidth = 8,
   parameter int unsigned K        = 32,
   parameter int unsigned AccBeats = 16,
   parameter int unsigned AccWidth = 2 * BitWidth + $clog2(K) + $clog2(AccBeats),
   parameter int unsigned BeatW    = $clog2(AccBeats) + 1
);
   logic                           i_valid;
   logic                           o_ready;
   logic [K-1:0][BitWidth-1:0]     i_vec_a;
   logic [K-1:0][BitWidth-1:0]     i_vec_b;
   logic                           i_signed;
   logic                           i_last;
   logic                           o_valid;
   logic                           i_ready;
   logic [AccWidth-1:0]            o_dp;
   logic [BeatW-1:0]               o_beats;

   // Engine side.
   modport slave (
      input  i_valid,
      input  i_vec_a,
      input  i_vec_b,
      input  i_signed,
      input  i_last,
      input  i_ready,
      output o_ready,
      output o_valid,
      output o_dp,
      output o_beats
   );

   // Producer/consumer side.
   modport master (
      output i_valid,
      output i_vec_a,
      output i_vec_b,
      output i_signed,
      output i_last,
      output i_ready,
      input  o_ready,
      input  o_valid,
      input  o_dp,
      input  o_beats
   );
endinterface

// File: rtl/dot_int_acc_pipe.sv
// Four-stage pipelined integer dot product with per-beat signed/unsigned mode and
// multi-beat accumulation. A single global stall freezes every stage while a result
// waits on the downstream consumer.
module dot_int_acc_pipe #(
   parameter int unsigned BitWidth = 8,
   parameter int unsigned K        = 32,
   parameter int unsigned PrdWidth = 2 * BitWidth,
   parameter int unsigned SumWidth = PrdWidth + $clog2(K),
   parameter int unsigned AccBeats = 16,
   parameter int unsigned AccWidth = SumWidth + $clog2(AccBeats)
) (
   input logic               i_clk,
   input logic               i_rst,
   dot_int_acc_pipe_if.slave bus
);
   localparam int unsigned BeatW   = $clog2(AccBeats) + 1;
   localparam int unsigned ExtW    = BitWidth + 1;
   localparam int unsigned PrdExtW = PrdWidth + 2;
   localparam int unsigned SumExtW = SumWidth + 1;

   typedef logic [K-1:0][BitWidth-1:0] vec_t;

   logic stall;

   // S1: input registers
   logic s1_valid_q, s1_valid_d;
   vec_t s1_a_q, s1_a_d;
   vec_t s1_b_q, s1_b_d;
   logic s1_sgn_q, s1_sgn_d;
   logic s1_last_q, s1_last_d;

   // S2: per-lane products
   logic                      s2_valid_q, s2_valid_d;
   logic                      s2_last_q, s2_last_d;
   logic signed [PrdExtW-1:0] prod_q [K];
   logic signed [PrdExtW-1:0] prod_d [K];

   // S3: reduced sum
   logic                      s3_valid_q, s3_valid_d;
   logic                      s3_last_q, s3_last_d;
   logic signed [SumExtW-1:0] sum_q, sum_d;

   // S4: accumulator and output registers
   logic [AccWidth-1:0] acc_q, acc_d;
   logic                start_q, start_d;
   logic [BeatW-1:0]    cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [AccWidth-1:0] dp_q, dp_d;
   logic [BeatW-1:0]    beats_q, beats_d;

   // A held result blocks the whole pipe; o_ready is purely combinational on that.
   always_comb begin
      stall = out_valid_q & ~bus.i_ready;
   end

   assign bus.o_ready = ~stall;
   assign bus.o_valid = out_valid_q;
   assign bus.o_dp    = dp_q;
   assign bus.o_beats = beats_q;

   // S1 next state: capture a beat when it is accepted.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_sgn_d   = s1_sgn_q;
      s1_last_d  = s1_last_q;
      if (!stall) begin
         s1_valid_d = bus.i_valid;
         if (bus.i_valid) begin
            s1_a_d    = bus.i_vec_a;
            s1_b_d    = bus.i_vec_b;
            s1_sgn_d  = bus.i_signed;
            s1_last_d = bus.i_last;
         end
      end
   end

   // S1 state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sgn_q   <= 1'b0;
         s1_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_last_q  <= s1_last_d;
      end
   end

   // S2 next state: extend each element by one bit according to the beat mode and multiply.
   // The extra bit makes unsigned operands non-negative in a signed multiplier.
   always_comb begin
      logic signed [ExtW-1:0] a_ext;
      logic signed [ExtW-1:0] b_ext;
      a_ext      = '0;
      b_ext      = '0;
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
      for (int i = 0; i < K; i++) begin
         prod_d[i] = prod_q[i];
      end
      if (!stall) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_last_d = s1_last_q;
            for (int i = 0; i < K; i++) begin
               a_ext     = signed'({s1_sgn_q & s1_a_q[i][BitWidth-1], s1_a_q[i]});
               b_ext     = signed'({s1_sgn_q & s1_b_q[i][BitWidth-1], s1_b_q[i]});
               prod_d[i] = PrdExtW'(a_ext) * PrdExtW'(b_ext);
            end
         end
      end
   end

   // S2 state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         for (int i = 0; i < K; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
         for (int i = 0; i < K; i++) begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

   // S3 next state: sign-extended reduction of all lane products.
   always_comb begin
      logic signed [SumExtW-1:0] tree_sum;
      tree_sum   = '0;
      s3_valid_d = s3_valid_q;
      s3_last_d  = s3_last_q;
      sum_d      = sum_q;
      if (!stall) begin
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            s3_last_d = s2_last_q;
            for (int i = 0; i < K; i++) begin
               tree_sum = tree_sum + SumExtW'(prod_q[i]);
            end
            sum_d = tree_sum;
         end
      end
   end

   // S3 state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s3_valid_q <= 1'b0;
         s3_last_q  <= 1'b0;
         sum_q      <= '0;
      end else begin
         s3_valid_q <= s3_valid_d;
         s3_last_q  <= s3_last_d;
         sum_q      <= sum_d;
      end
   end

   // S4 next state: accumulate modulo 2^AccWidth, publish on the last beat of a group.
   // When not stalled any held result is being transferred, so o_valid may drop or be
   // reloaded in the same cycle without a bubble.
   always_comb begin
      logic [AccWidth-1:0] sum_acc;
      logic [AccWidth-1:0] acc_new;
      logic [BeatW-1:0]    cnt_new;
      sum_acc     = AccWidth'(sum_q);
      acc_new     = start_q ? sum_acc : acc_q + sum_acc;
      cnt_new     = (cnt_q == BeatW'(AccBeats)) ? cnt_q : cnt_q + BeatW'(1);
      acc_d       = acc_q;
      start_d     = start_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      dp_d        = dp_q;
      beats_d     = beats_q;
      if (!stall) begin
         out_valid_d = 1'b0;
         if (s3_valid_q) begin
            acc_d   = acc_new;
            cnt_d   = cnt_new;
            start_d = 1'b0;
            if (s3_last_q) begin
               out_valid_d = 1'b1;
               dp_d        = acc_new;
               beats_d     = cnt_new;
               start_d     = 1'b1;
               cnt_d       = '0;
            end
         end
      end
   end

   // S4 state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_q       <= '0;
         start_q     <= 1'b1;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         dp_q        <= '0;
         beats_q     <= '0;
      end else begin
         acc_q       <= acc_d;
         start_q     <= start_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         dp_q        <= dp_d;
         beats_q     <= beats_d;
      end
   end

endmodule

// File: tb/tb_dot_int_acc_pipe.sv
// Bench for dot_int_acc_pipe: scoreboard of expected group results fed by a reference
// model at beat acceptance, drained against results the DUT hands over.
module tb_dot_int_acc_pipe;
   localparam int unsigned BitWidth = 8;
   localparam int unsigned K        = 32;
   localparam int unsigned AccBeats = 16;
   localparam int unsigned AccWidth = 2 * BitWidth + $clog2(K) + $clog2(AccBeats);
   localparam int unsigned BeatW    = $clog2(AccBeats) + 1;

   typedef logic [K-1:0][BitWidth-1:0] vec_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   dot_int_acc_pipe_if #(
      .BitWidth(BitWidth),
      .K       (K),
      .AccBeats(AccBeats),
      .AccWidth(AccWidth),
      .BeatW   (BeatW)
   ) bus ();

   dot_int_acc_pipe #(
      .BitWidth(BitWidth),
      .K       (K),
      .AccBeats(AccBeats)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_lo = -1;
   int rdy_hi = -1;
   bit saw_stall = 1'b0;

   logic [AccWidth-1:0] exp_dp[$];
   logic [BeatW-1:0]    exp_beats[$];
   logic [AccWidth-1:0] obs_dp[$];
   logic [BeatW-1:0]    obs_beats[$];

   logic signed [63:0] mdl_acc = '0;
   int                 mdl_cnt = 0;
   bit                 mdl_start = 1'b1;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Record every transferred result; inputs settle at negedge+1, so +2 sees this cycle's pair.
   initial begin
      forever begin
         @(negedge i_clk);
         #2;
         if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            obs_dp.push_back(bus.o_dp);
            obs_beats.push_back(bus.o_beats);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, required=finish");
      $fatal(1);
   end

   function automatic bit ready_now();
      return !(cyc >= rdy_lo && cyc < rdy_hi);
   endfunction

   task automatic model_accept(input vec_t a, input vec_t b, input bit sgn, input bit last);
      logic signed [63:0] s;
      int ae;
      int be;
      s = '0;
      for (int i = 0; i < K; i++) begin
         ae = sgn ? int'($signed(a[i])) : int'(a[i]);
         be = sgn ? int'($signed(b[i])) : int'(b[i]);
         s  = s + 64'(ae * be);
      end
      mdl_acc   = mdl_start ? s : mdl_acc + s;
      mdl_cnt   = (mdl_cnt < AccBeats) ? mdl_cnt + 1 : mdl_cnt;
      mdl_start = 1'b0;
      if (last) begin
         exp_dp.push_back(mdl_acc[AccWidth-1:0]);
         exp_beats.push_back(BeatW'(mdl_cnt));
         mdl_start = 1'b1;
         mdl_cnt   = 0;
      end
   endtask

   task automatic send_beat(input vec_t a, input vec_t b, input bit sgn, input bit last);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge i_clk);
         #1;
         bus.i_valid  = 1'b1;
         bus.i_vec_a  = a;
         bus.i_vec_b  = b;
         bus.i_signed = sgn;
         bus.i_last   = last;
         bus.i_ready  = ready_now();
         #1;
         if (bus.o_ready === 1'b1) begin
            done = 1'b1;
            model_accept(a, b, sgn, last);
         end else begin
            saw_stall = 1'b1;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_beat: accepted=0 required=1");
      end
   endtask

   task automatic idle_cycle();
      @(negedge i_clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_ready = ready_now();
      #1;
   endtask

   task automatic wait_results(input int n);
      for (int t = 0; t < 80 && obs_dp.size() < n; t++) idle_cycle();
      for (int t = 0; t < 8; t++) idle_cycle();
   endtask

   function automatic vec_t fill(input logic [BitWidth-1:0] v);
      vec_t r;
      for (int i = 0; i < K; i++) r[i] = v;
      return r;
   endfunction

   task automatic test_reset();
      bus.i_valid  = 1'b0;
      bus.i_vec_a  = '0;
      bus.i_vec_b  = '0;
      bus.i_signed = 1'b0;
      bus.i_last   = 1'b0;
      bus.i_ready  = 1'b0;
      i_rst        = 1'b1;
      repeat (3) @(negedge i_clk);
      #2;
      total++;
      if (bus.o_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_o_valid: got=%b want=0", bus.o_valid);
      end
      total++;
      if (bus.o_dp !== '0) begin
         bad++;
         $display("FAIL reset_o_dp: got=%0d want=0", bus.o_dp);
      end
      total++;
      if (bus.o_beats !== '0) begin
         bad++;
         $display("FAIL reset_o_beats: got=%0d want=0", bus.o_beats);
      end
      total++;
      if (bus.o_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_o_ready: got=%b want=1", bus.o_ready);
      end
      @(negedge i_clk);
      #1;
      i_rst       = 1'b0;
      bus.i_ready = 1'b1;
   endtask

   task automatic test_unsigned_single();
      send_beat(fill(8'd255), fill(8'd255), 1'b0, 1'b1);
      wait_results(1);
      total++;
      if (obs_dp.size() != 1) begin
         bad++;
         $display("FAIL unsigned_count: got=%0d want=1", obs_dp.size());
      end
      while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed) begin bad++; $display("FAIL unsigned_dp: got=%0d want=%0d", d, ed); end
         total++;
         if (d !== AccWidth'(2080800)) begin
            bad++; $display("FAIL unsigned_dp_lit: got=%0d want=2080800", d);
         end
         total++;
         if (b !== eb || b !== BeatW'(1)) begin
            bad++; $display("FAIL unsigned_beats: got=%0d want=1", b);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   task automatic test_signed_single();
      send_beat(fill(8'h80), fill(8'd127), 1'b1, 1'b1);
      wait_results(1);
      total++;
      if (obs_dp.size() != 1) begin
         bad++;
         $display("FAIL signed_count: got=%0d want=1", obs_dp.size());
      end
      while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed) begin bad++; $display("FAIL signed_dp: got=%h want=%h", d, ed); end
         total++;
         if (d !== AccWidth'(-520192)) begin
            bad++; $display("FAIL signed_dp_lit: got=%h want=%h", d, AccWidth'(-520192));
         end
         total++;
         if (b !== eb || b !== BeatW'(1)) begin
            bad++; $display("FAIL signed_beats: got=%0d want=1", b);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   task automatic test_accumulate();
      vec_t ramp;
      for (int i = 0; i < K; i++) ramp[i] = BitWidth'(i);
      send_beat(fill(8'd1), ramp, 1'b0, 1'b0);
      send_beat(fill(8'd1), ramp, 1'b0, 1'b0);
      send_beat(fill(8'd1), ramp, 1'b0, 1'b1);
      wait_results(1);
      total++;
      if (obs_dp.size() != 1) begin
         bad++;
         $display("FAIL accum_count: got=%0d want=1", obs_dp.size());
      end
      while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed || d !== AccWidth'(1488)) begin
            bad++; $display("FAIL accum_dp: got=%0d want=%0d", d, ed);
         end
         total++;
         if (b !== eb || b !== BeatW'(3)) begin
            bad++; $display("FAIL accum_beats: got=%0d want=3", b);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   task automatic test_back_to_back();
      vec_t a;
      vec_t one;
      saw_stall = 1'b0;
      rdy_lo    = cyc + 4;
      rdy_hi    = cyc + 9;
      one       = '0;
      one[0]    = 8'd1;
      for (int v = 1; v <= 6; v++) begin
         a    = '0;
         a[0] = BitWidth'(v);
         send_beat(a, one, 1'b0, 1'b1);
      end
      wait_results(6);
      rdy_lo = -1;
      rdy_hi = -1;
      total++;
      if (saw_stall !== 1'b1) begin
         bad++;
         $display("FAIL b2b_o_ready_drop: got=%b want=1", saw_stall);
      end
      total++;
      if (obs_dp.size() != 6) begin
         bad++;
         $display("FAIL b2b_count: got=%0d want=6", obs_dp.size());
      end
      for (int v = 1; v <= 6 && obs_dp.size() > 0 && exp_dp.size() > 0; v++) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed || d !== AccWidth'(v)) begin
            bad++; $display("FAIL b2b_dp[%0d]: got=%0d want=%0d", v, d, v);
         end
         total++;
         if (b !== eb) begin
            bad++; $display("FAIL b2b_beats[%0d]: got=%0d want=%0d", v, b, eb);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   task automatic test_reset_mid_group();
      vec_t a;
      vec_t one;
      one    = '0;
      one[0] = 8'd1;
      a      = '0;
      a[0]   = 8'd3;
      send_beat(a, one, 1'b0, 1'b0);
      a[0]   = 8'd4;
      send_beat(a, one, 1'b0, 1'b0);
      @(negedge i_clk);
      #1;
      bus.i_valid = 1'b0;
      i_rst       = 1'b1;
      @(negedge i_clk);
      #1;
      i_rst     = 1'b0;
      mdl_start = 1'b1;
      mdl_cnt   = 0;
      a[0]      = 8'd7;
      send_beat(a, one, 1'b0, 1'b1);
      wait_results(1);
      total++;
      if (obs_dp.size() != 1) begin
         bad++;
         $display("FAIL rstmid_count: got=%0d want=1", obs_dp.size());
      end
      while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed || d !== AccWidth'(7)) begin
            bad++; $display("FAIL rstmid_dp: got=%0d want=7", d);
         end
         total++;
         if (b !== eb || b !== BeatW'(1)) begin
            bad++; $display("FAIL rstmid_beats: got=%0d want=1", b);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   task automatic test_overflow_wrap();
      for (int n = 1; n <= 17; n++) begin
         send_beat(fill(8'd255), fill(8'd255), 1'b0, n == 17);
      end
      wait_results(1);
      total++;
      if (obs_dp.size() != 1) begin
         bad++;
         $display("FAIL wrap_count: got=%0d want=1", obs_dp.size());
      end
      while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
         logic [AccWidth-1:0] d;
         logic [BeatW-1:0]    b;
         logic [AccWidth-1:0] ed;
         logic [BeatW-1:0]    eb;
         d = obs_dp.pop_front();  b = obs_beats.pop_front();
         ed = exp_dp.pop_front(); eb = exp_beats.pop_front();
         total++;
         if (d !== ed || d !== AccWidth'(35373600)) begin
            bad++; $display("FAIL wrap_dp: got=%0d want=%0d", d, AccWidth'(35373600));
         end
         total++;
         if (b !== eb || b !== BeatW'(16)) begin
            bad++; $display("FAIL wrap_beats: got=%0d want=16", b);
         end
      end
      obs_dp.delete(); obs_beats.delete(); exp_dp.delete(); exp_beats.delete();
   endtask

   initial begin
      test_reset();
      test_unsigned_single();
      test_signed_single();
      test_accumulate();
      test_back_to_back();
      test_reset_mid_group();
      test_overflow_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
